// File: rtl/decodificador_bus_invert_pkg.sv
// Shared constants and types for the bus-invert receive decoder.
package decodificador_bus_invert_pkg;
  localparam int DEF_W      = 8;
  localparam int DEF_CNT_W  = 16;
  localparam int HALF_W     = DEF_W / 2;
  localparam int FIFO_DEPTH = 2;

  typedef logic [DEF_W-1:0] word_t;
endpackage

// File: rtl/decodificador_bus_invert_contagem_bits.sv
// Combinational population count of a W-bit vector.
module contagem_bits #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] count_o
);

  // NOTE: combinational logic uses blocking '=' so the running sum is read
  // back within the same pass; clocked state always uses '<='.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/decodificador_bus_invert.sv
// Bus-invert receive decoder with toggle-rule checker, inversion counter and
// 2-entry skid FIFO. Define BUS_INVERT_PARITY_EN to add the in_par/par_err check.
module decodificador_bus_invert
  import decodificador_bus_invert_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_bus,
  input  logic             in_inv,
`ifdef BUS_INVERT_PARITY_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             rule_err,
  output logic [CNT_W-1:0] inv_count,
  input  logic             clr
);

  localparam int PW = $clog2(W + 1);
  localparam logic [PW-1:0] HALF_C  = PW'(W / 2);
  localparam logic [1:0]    DEPTH_C = 2'(FIFO_DEPTH);

  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [W-1:0]     mem_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [W-1:0]     prev_bus_q, prev_bus_d;
  logic             rule_err_q, rule_err_d;
  logic [CNT_W-1:0] inv_count_q, inv_count_d;

  logic          accept, pop;
  logic [W-1:0]  decoded;
  logic [PW-1:0] toggles;

  // Handshake depends only on registered count, so no in->out or out_ready->in_ready path.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign rule_err  = rule_err_q;
  assign inv_count = inv_count_q;

  assign accept  = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign decoded = in_bus ^ {W{in_inv}};

  contagem_bits #(.W(W), .CW(PW)) u_contagem_bits (
    .vec_i   (in_bus ^ prev_bus_q),
    .count_o (toggles)
  );

  // NOTE: every _d gets its hold value first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    prev_bus_d  = prev_bus_q;
    rule_err_d  = rule_err_q;
    inv_count_d = inv_count_q;

    if (accept) begin
      mem_d[wr_ptr_q] = decoded;
      wr_ptr_d        = ~wr_ptr_q;
      prev_bus_d      = in_bus;
      if (toggles > HALF_C) rule_err_d = 1'b1;
      if (in_inv && (inv_count_q != {CNT_W{1'b1}})) inv_count_d = inv_count_q + 1'b1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Clear has priority over a same-cycle event; prev_bus is untouched.
    if (clr) begin
      rule_err_d  = 1'b0;
      inv_count_d = '0;
    end
  end

  // NOTE: storage is reset too, because out_data must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      prev_bus_q  <= '0;
      rule_err_q  <= 1'b0;
      inv_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prev_bus_q  <= prev_bus_d;
      rule_err_q  <= rule_err_d;
      inv_count_q <= inv_count_d;
    end
  end

`ifdef BUS_INVERT_PARITY_EN
  logic par_err_q, par_err_d;
  logic par_mismatch;

  // Even parity: in_par, in_inv and in_bus together must XOR to zero.
  assign par_mismatch = ^{in_par, in_inv, in_bus};
  assign par_err      = par_err_q;

  always_comb begin
    par_err_d = par_err_q;
    if (accept && par_mismatch) par_err_d = 1'b1;
    if (clr) par_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
`endif

endmodule

// File: tb/tb_decodificador_bus_invert.sv
// Directed self-checking bench: vector table plus backpressure, streaming,
// saturation (CNT_W=2 instance) and mid-operation reset sequences.
module tb_decodificador_bus_invert;
  import decodificador_bus_invert_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_inv, out_valid, out_ready, rule_err, clr;
  word_t       in_bus, out_data;
  logic [15:0] inv_count;
`ifdef BUS_INVERT_PARITY_EN
  logic        in_par, par_err;
  logic        in_par2, par_err2;
`endif

  logic        in_valid2, in_ready2, in_inv2, out_valid2, out_ready2, rule_err2, clr2;
  word_t       in_bus2, out_data2;
  logic [1:0]  inv_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decodificador_bus_invert #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bus(in_bus), .in_inv(in_inv),
`ifdef BUS_INVERT_PARITY_EN
    .in_par(in_par), .par_err(par_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rule_err(rule_err), .inv_count(inv_count), .clr(clr)
  );

  decodificador_bus_invert #(.W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_bus(in_bus2), .in_inv(in_inv2),
`ifdef BUS_INVERT_PARITY_EN
    .in_par(in_par2), .par_err(par_err2),
`endif
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .rule_err(rule_err2), .inv_count(inv_count2), .clr(clr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input word_t b, input logic inv, input logic c);
    in_valid = v;
    in_bus   = b;
    in_inv   = inv;
    clr      = c;
`ifdef BUS_INVERT_PARITY_EN
    in_par   = ^{inv, b};
`endif
  endtask

  typedef struct {
    word_t       bus;
    logic        inv;
    logic        clr;
    word_t       exp_data;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{8'h0F, 1'b1, 1'b0, 8'hF0, 1'b0, 16'd1}; // t=4 legal
    vecs[1] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1}; // t=4 legal
    vecs[2] = '{8'h1F, 1'b0, 1'b0, 8'h1F, 1'b1, 16'd1}; // t=5 violation
    vecs[3] = '{8'h1E, 1'b1, 1'b0, 8'hE1, 1'b1, 16'd2}; // sticky
    vecs[4] = '{8'h1E, 1'b0, 1'b0, 8'h1E, 1'b1, 16'd2};
    vecs[5] = '{8'h11, 1'b1, 1'b1, 8'hEE, 1'b0, 16'd0}; // clr beats increment
    vecs[6] = '{8'hEE, 1'b0, 1'b0, 8'hEE, 1'b1, 16'd0}; // t=8
    vecs[7] = '{8'h11, 1'b1, 1'b0, 8'hEE, 1'b1, 16'd1};
    vecs[8] = '{8'hEE, 1'b0, 1'b1, 8'hEE, 1'b0, 16'd0}; // clr beats violation

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    out_ready  = 1'b1;
    in_valid2  = 1'b0; in_bus2 = 8'h00; in_inv2 = 1'b0; clr2 = 1'b0; out_ready2 = 1'b1;
`ifdef BUS_INVERT_PARITY_EN
    in_par2 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("reset out_valid", out_valid, 0);
    check("reset in_ready",  in_ready, 1);
    check("reset out_data",  out_data, 0);
    check("reset rule_err",  rule_err, 0);
    check("reset inv_count", inv_count, 0);

    // Vector table: one accept per row, output checked one cycle later.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].bus, vecs[i].inv, vecs[i].clr);
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d out_data", i),  out_data, vecs[i].exp_data);
      check($sformatf("vec%0d rule_err", i),  rule_err, vecs[i].exp_err);
      check($sformatf("vec%0d inv_count", i), inv_count, vecs[i].exp_cnt);
`ifdef BUS_INVERT_PARITY_EN
      check($sformatf("vec%0d par_err", i),   par_err, 0);
`endif
    end
    @(negedge clk);
    check("drain out_valid", out_valid, 0);

    // Backpressure: three words offered while the consumer stalls.
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    check("bp in_ready after 1", in_ready, 1);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    check("bp in_ready full", in_ready, 0);
    check("bp head", out_data, 8'h11);
    repeat (2) @(negedge clk);
    check("bp in_ready held", in_ready, 0);
    check("bp head held", out_data, 8'h11);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp pop1 data", out_data, 8'h22);
    check("bp pop1 in_ready", in_ready, 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("bp pop2 valid", out_valid, 1);
    check("bp pop2 data", out_data, 8'h33);
    @(negedge clk);
    check("bp empty", out_valid, 0);

    // Streaming: one word per cycle with one cycle of latency.
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        check($sformatf("stream%0d valid", i - 1), out_valid, 1);
        check($sformatf("stream%0d data", i - 1),  out_data, 8'h40 + i - 1);
        check($sformatf("stream%0d in_ready", i - 1), in_ready, 1);
      end
      if (i < 10) drive(1'b1, 8'h40 + i[7:0], 1'b0, 1'b0);
      else        drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
    end
    check("stream drained", out_valid, 0);

    // Reset with both entries buffered discards them.
    out_ready = 1'b0;
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre-reset full", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset out_valid", out_valid, 0);
    check("midreset in_ready",  in_ready, 1);
    check("midreset out_data",  out_data, 0);
    check("midreset inv_count", inv_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midreset no word %0d", i), out_valid, 0);
    end

    // Saturation on the CNT_W=2 instance, then clr with a same-cycle increment.
    for (int i = 0; i < 6; i++) begin
      in_valid2 = 1'b1; in_bus2 = 8'h00; in_inv2 = 1'b1; clr2 = (i == 5);
`ifdef BUS_INVERT_PARITY_EN
      in_par2 = 1'b1;
`endif
      @(negedge clk);
      in_valid2 = 1'b0; clr2 = 1'b0;
      check($sformatf("sat inv_count %0d", i), inv_count2,
            (i == 5) ? 0 : ((i >= 2) ? 3 : i + 1));
      check($sformatf("sat out_data %0d", i), out_data2, 8'hFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
